// File: rtl/gate_drive_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gate_drive_pkg
// Purpose  : State encoding and default parameters for the gate-drive block.
// Revision : 1.0
// ============================================================================
package gate_drive_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SOFT_START = 2'd1,
        ST_RUN        = 2'd2,
        ST_FAULT      = 2'd3
    } state_t;

    localparam int N_DEF       = 8;
    localparam int DT_W_DEF    = 6;
    localparam int PRESC_W_DEF = 8;
    localparam int RAMP_DEF    = 4;

endpackage
`default_nettype wire

// File: rtl/dead_time_gen.sv
`default_nettype none
// ============================================================================
// Module   : dead_time_gen
// Purpose  : Complementary gate outputs with break-before-make dead time.
// Revision : 1.0
// ============================================================================
module dead_time_gen
    import gate_drive_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            raw,
    input  logic [DT_W-1:0] dead_time,
    output logic            gate_hi,
    output logic            gate_lo
);

    logic            r_raw_q;
    logic [DT_W-1:0] r_cnt;
    logic            w_edge;
    logic [DT_W-1:0] w_cnt_eff;

    assign w_edge    = raw ^ r_raw_q;
    // An edge restarts the count in the same cycle, so dead_time=0 passes raw through.
    assign w_cnt_eff = w_edge ? '0 : r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw_q <= 1'b0;
            r_cnt   <= '0;
            gate_hi <= 1'b0;
            gate_lo <= 1'b0;
        end else if (!en) begin
            r_raw_q <= raw;
            r_cnt   <= '0;
            gate_hi <= 1'b0;
            gate_lo <= 1'b0;
        end else begin
            r_raw_q <= raw;
            if (w_cnt_eff >= dead_time) begin
                r_cnt   <= w_cnt_eff;
                gate_hi <= raw;
                gate_lo <= ~raw;
            end else begin
                r_cnt   <= w_cnt_eff + DT_W'(1);
                gate_hi <= 1'b0;
                gate_lo <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gate_drive_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gate_drive_ctrl
// Purpose  : Half-bridge PWM controller with soft start, dead time and fault latch.
// Revision : 1.0
// ============================================================================
module gate_drive_ctrl
    import gate_drive_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int DT_W    = DT_W_DEF,
    parameter int PRESC_W = PRESC_W_DEF,
    parameter int RAMP    = RAMP_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [DT_W-1:0]    dead_time,
    input  logic               cmd_valid,
    input  logic [N-1:0]       cmd_duty,
    output logic               cmd_ready,
    input  logic               fault,
    input  logic               fault_clr,
    output logic               gate_hi,
    output logic               gate_lo,
    output logic               period_start,
    output logic [N-1:0]       duty_act,
    output logic [1:0]         state,
    output logic               fault_latched
);

    localparam logic [N-1:0] c_duty_max = '1;

    state_t             r_state, w_state_nxt;
    logic [PRESC_W-1:0] r_presc;
    logic [N-1:0]       r_cnt, r_duty, r_shadow, r_target;
    logic               r_pending, r_fault_latched;

    logic               w_running, w_keep, w_tick, w_boundary, w_accept;
    logic               w_ramp_done, w_raw, w_gate_en;
    logic [N-1:0]       w_target_nxt;
    logic [N:0]         w_sum;

    assign w_running    = (r_state == ST_SOFT_START) || (r_state == ST_RUN);
    assign w_keep       = w_running && ena && !fault;
    assign w_tick       = w_running && (r_presc == prescale);
    assign w_boundary   = w_tick && (r_cnt == c_duty_max);
    assign w_accept     = cmd_valid && cmd_ready;
    // Ramp and run both use the target that is being loaded on this boundary.
    assign w_target_nxt = (w_boundary && r_pending) ? r_shadow : r_target;
    assign w_sum        = {1'b0, r_duty} + (N+1)'(RAMP);
    assign w_ramp_done  = ({1'b0, w_target_nxt} <= w_sum);
    assign w_raw        = (r_cnt < r_duty) || (r_duty == c_duty_max);
    // Gates are keyed off the next state so shutdown is visible one clock after the cause.
    assign w_gate_en    = (w_state_nxt == ST_SOFT_START) || (w_state_nxt == ST_RUN);

    always_comb begin
        w_state_nxt = r_state;
        if (fault) begin
            w_state_nxt = ST_FAULT;
        end else if (r_state == ST_FAULT) begin
            if (fault_clr && !ena) w_state_nxt = ST_IDLE;
        end else if (!ena) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:       w_state_nxt = ST_SOFT_START;
                ST_SOFT_START: if (w_boundary && w_ramp_done) w_state_nxt = ST_RUN;
                default:       w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_fault_latched <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_fault_latched <= (w_state_nxt == ST_FAULT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_cnt   <= '0;
            r_duty  <= '0;
        end else if (!w_keep) begin
            r_presc <= '0;
            r_cnt   <= '0;
            r_duty  <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
            if (w_tick) r_cnt <= r_cnt + N'(1);
            if (w_boundary) begin
                if (r_state == ST_SOFT_START && !w_ramp_done) r_duty <= w_sum[N-1:0];
                else                                          r_duty <= w_target_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_target  <= '0;
            r_pending <= 1'b0;
        end else if (fault) begin
            r_pending <= 1'b0;
        end else if (w_accept) begin
            r_shadow  <= cmd_duty;
            r_pending <= 1'b1;
        end else if (w_boundary && r_pending) begin
            r_target  <= r_shadow;
            r_pending <= 1'b0;
        end
    end

    dead_time_gen #(
        .DT_W (DT_W)
    ) u_dead_time_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (w_gate_en),
        .raw       (w_raw),
        .dead_time (dead_time),
        .gate_hi   (gate_hi),
        .gate_lo   (gate_lo)
    );

    assign cmd_ready     = !r_pending && (r_state != ST_FAULT);
    assign period_start  = w_boundary;
    assign duty_act      = r_duty;
    assign state         = r_state;
    assign fault_latched = r_fault_latched;

endmodule
`default_nettype wire

// File: tb/tb_gate_drive_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_drive_ctrl
// Purpose  : Directed self-checking bench for gate_drive_ctrl.
// Revision : 1.0
// ============================================================================
module tb_gate_drive_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] prescale;
    logic [5:0] dead_time;
    logic       cmd_valid;
    logic [7:0] cmd_duty;
    logic       cmd_ready;
    logic       fault;
    logic       fault_clr;
    logic       gate_hi;
    logic       gate_lo;
    logic       period_start;
    logic [7:0] duty_act;
    logic [1:0] state;
    logic       fault_latched;

    int errors = 0;
    int checks = 0;

    gate_drive_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .prescale      (prescale),
        .dead_time     (dead_time),
        .cmd_valid     (cmd_valid),
        .cmd_duty      (cmd_duty),
        .cmd_ready     (cmd_ready),
        .fault         (fault),
        .fault_clr     (fault_clr),
        .gate_hi       (gate_hi),
        .gate_lo       (gate_lo),
        .period_start  (period_start),
        .duty_act      (duty_act),
        .state         (state),
        .fault_latched (fault_latched)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance to the next boundary cycle, then across the edge that applies it.
    task automatic wait_bnd(input string tag);
        int n;
        n = 0;
        while (period_start !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        chk({tag, "_boundary"}, {31'd0, period_start}, 32'd1);
        tick();
    endtask

    task automatic send_cmd(input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_duty  = d;
        #1;
        chk("send_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hi_n, lo_n, both_n, ovl_n, bad_n;

        rst_n = 1'b0; ena = 1'b0; prescale = 8'd0; dead_time = 6'd5;
        cmd_valid = 1'b0; cmd_duty = 8'd0; fault = 1'b0; fault_clr = 1'b0;
        ticks(2);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_gate_hi", {31'd0, gate_hi}, 32'd0);
        chk("rst_gate_lo", {31'd0, gate_lo}, 32'd0);
        chk("rst_period_start", {31'd0, period_start}, 32'd0);
        chk("rst_fault_latched", {31'd0, fault_latched}, 32'd0);
        chk("rst_duty_act", {24'd0, duty_act}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        rst_n = 1'b1;
        ticks(2);
        chk("idle_hold_state", {30'd0, state}, 32'd0);

        // Soft-start ramp to 64
        send_cmd(8'd64);
        #1;
        chk("pending_ready", {31'd0, cmd_ready}, 32'd0);
        ena = 1'b1;
        tick();
        chk("ss_state", {30'd0, state}, 32'd1);
        n = 0;
        while (period_start !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        chk("first_boundary_delay", n, 32'd255);
        for (int j = 1; j <= 16; j++) begin
            wait_bnd("ramp");
            chk($sformatf("ramp_duty_%0d", j), {24'd0, duty_act}, 4 * j);
            chk($sformatf("ramp_state_%0d", j), {30'd0, state}, (j == 16) ? 32'd2 : 32'd1);
            if (j == 1) chk("ramp_ready_after_load", {31'd0, cmd_ready}, 32'd1);
        end

        // Dead time at duty 128, one full period
        send_cmd(8'd128);
        wait_bnd("dt");
        chk("dt_duty", {24'd0, duty_act}, 32'd128);
        hi_n = 0; lo_n = 0; both_n = 0; ovl_n = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (gate_hi) hi_n++;
            if (gate_lo) lo_n++;
            if (!gate_hi && !gate_lo) both_n++;
            if (gate_hi && gate_lo) ovl_n++;
        end
        chk("dt_hi_cycles", hi_n, 32'd123);
        chk("dt_lo_cycles", lo_n, 32'd123);
        chk("dt_both_low", both_n, 32'd10);
        chk("dt_overlap", ovl_n, 32'd0);

        // Handshake: second command held until the pending one loads
        send_cmd(8'd100);
        cmd_valid = 1'b1;
        cmd_duty  = 8'd200;
        #1;
        chk("hs_ready_blocked", {31'd0, cmd_ready}, 32'd0);
        bad_n = 0;
        n = 0;
        while (period_start !== 1'b1 && n < 1000) begin
            if (cmd_ready) bad_n++;
            tick();
            n++;
        end
        chk("hs_ready_low_until_bnd", bad_n + {31'd0, cmd_ready}, 32'd0);
        chk("hs_boundary", {31'd0, period_start}, 32'd1);
        tick();
        chk("hs_duty_first", {24'd0, duty_act}, 32'd100);
        chk("hs_ready_after_load", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("hs_second_accepted", {31'd0, cmd_ready}, 32'd0);
        wait_bnd("hs2");
        chk("hs_duty_second", {24'd0, duty_act}, 32'd200);

        // Extremes
        send_cmd(8'd255);
        wait_bnd("max");
        chk("max_duty", {24'd0, duty_act}, 32'd255);
        ticks(10);
        bad_n = 0;
        for (int i = 0; i < 300; i++) begin
            if (!(gate_hi === 1'b1 && gate_lo === 1'b0)) bad_n++;
            tick();
        end
        chk("max_gate_hi_const", bad_n, 32'd0);
        send_cmd(8'd0);
        wait_bnd("zero");
        chk("zero_duty", {24'd0, duty_act}, 32'd0);
        ticks(10);
        bad_n = 0;
        for (int i = 0; i < 300; i++) begin
            if (!(gate_hi === 1'b0 && gate_lo === 1'b1)) bad_n++;
            tick();
        end
        chk("zero_gate_lo_const", bad_n, 32'd0);

        // Fault entry, ignored clear, proper clear
        send_cmd(8'd50);
        ticks(20);
        fault = 1'b1;
        tick();
        fault = 1'b0;
        chk("flt_gate_hi", {31'd0, gate_hi}, 32'd0);
        chk("flt_gate_lo", {31'd0, gate_lo}, 32'd0);
        chk("flt_state", {30'd0, state}, 32'd3);
        chk("flt_latched", {31'd0, fault_latched}, 32'd1);
        chk("flt_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("flt_duty", {24'd0, duty_act}, 32'd0);
        fault_clr = 1'b1;
        ticks(3);
        chk("flt_clr_ena_ignored", {30'd0, state}, 32'd3);
        chk("flt_clr_ena_latched", {31'd0, fault_latched}, 32'd1);
        ena = 1'b0;
        tick();
        fault_clr = 1'b0;
        chk("flt_exit_state", {30'd0, state}, 32'd0);
        chk("flt_exit_latched", {31'd0, fault_latched}, 32'd0);
        chk("flt_exit_ready", {31'd0, cmd_ready}, 32'd1);

        // Target 0 survives: soft start finishes immediately, then RUN at 128
        ena = 1'b1;
        tick();
        wait_bnd("rerun");
        chk("rerun_state", {30'd0, state}, 32'd2);
        chk("rerun_duty", {24'd0, duty_act}, 32'd0);
        send_cmd(8'd128);
        wait_bnd("rerun128");
        chk("rerun_duty128", {24'd0, duty_act}, 32'd128);
        ticks(60);
        chk("pre_rst_gate_hi", {31'd0, gate_hi}, 32'd1);

        // Asynchronous reset between clock edges
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_state", {30'd0, state}, 32'd0);
        chk("arst_gate_hi", {31'd0, gate_hi}, 32'd0);
        chk("arst_gate_lo", {31'd0, gate_lo}, 32'd0);
        chk("arst_duty", {24'd0, duty_act}, 32'd0);
        chk("arst_latched", {31'd0, fault_latched}, 32'd0);
        chk("arst_period_start", {31'd0, period_start}, 32'd0);
        chk("arst_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        send_cmd(8'd64);
        chk("restart_state", {30'd0, state}, 32'd1);
        wait_bnd("restart");
        chk("restart_duty", {24'd0, duty_act}, 32'd4);
        chk("restart_state_ss", {30'd0, state}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
